// File: rtl/bomb_blast_if.sv
// Event-side bus between the bomb controller and the board/scan logic.
// The master drives the scan and player inputs. The slave returns the bomb requests and status.
interface bomb_blast_if;
  // Protocol: sof and place_req are one-cycle pulses. game_over is a level.
  // add_user_bomb stays high for one whole frame, from sof to the next sof.
  // explosion is a per-pixel level, one clk behind pixel_x/pixel_y.
  logic        sof;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        place_req;
  logic [4:0]  player_col;
  logic [3:0]  player_row;
  logic        game_over;
  logic        add_user_bomb;
  logic        explosion;
  logic        bomb_active;
  logic [7:0]  fuse_remaining;
  logic [2:0]  state;

  modport master (
    output sof, pixel_x, pixel_y, place_req, player_col, player_row, game_over,
    input  add_user_bomb, explosion, bomb_active, fuse_remaining, state
  );

  modport slave (
    input  sof, pixel_x, pixel_y, place_req, player_col, player_row, game_over,
    output add_user_bomb, explosion, bomb_active, fuse_remaining, state
  );
endinterface

// File: rtl/bomb_blast_controller.sv
// Bomb lifecycle controller: latches a placement, counts the fuse in frames,
// then paints a cross-shaped blast in step with the pixel scan.
module bomb_blast_controller #(
  parameter logic [10:0] X_MATRIX     = 11'h020,
  parameter logic [10:0] Y_MATRIX     = 11'h060,
  parameter int          ROWS         = 11,
  parameter int          COLUMNS      = 17,
  parameter int          TILE_ORDER   = 5,
  parameter logic [7:0]  FUSE_FRAMES  = 8'd120,
  parameter logic [7:0]  BLAST_FRAMES = 8'd30,
  parameter logic [2:0]  RADIUS       = 3'd2
) (
  input logic         clk,
  input logic         rst_n,
  bomb_blast_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLACE_WAIT = 3'd1,
    PLACING    = 3'd2,
    ARMED      = 3'd3,
    BLAST      = 3'd4
  } state_t;

  // Exclusive end coordinates are held at 12 bits so they cannot overflow.
  localparam logic [11:0] X_END = {1'b0, X_MATRIX} + 12'(COLUMNS << TILE_ORDER);
  localparam logic [11:0] Y_END = {1'b0, Y_MATRIX} + 12'(ROWS << TILE_ORDER);
  localparam logic [10:0] REACH = {8'd0, RADIUS};

  state_t      state, state_n;
  logic [4:0]  bomb_col, bomb_col_n;
  logic [3:0]  bomb_row, bomb_row_n;
  logic [7:0]  fuse_cnt, fuse_cnt_n;
  logic [7:0]  blast_cnt, blast_cnt_n;
  logic        add_user_bomb_q;
  logic        explosion_q;
  logic        bomb_active_q;

  // Pixel to tile mapping.
  logic        on_x, on_y, on_board;
  logic [10:0] dx, dy;
  logic [10:0] col, row;
  logic [10:0] bcol, brow;
  logic [10:0] col_diff, row_diff;
  logic        in_row_arm, in_col_arm, blast_hit;

  always_comb begin
    on_x     = (bus.pixel_x >= X_MATRIX) && ({1'b0, bus.pixel_x} < X_END);
    on_y     = (bus.pixel_y >= Y_MATRIX) && ({1'b0, bus.pixel_y} < Y_END);
    on_board = on_x && on_y;
    dx       = bus.pixel_x - X_MATRIX;
    dy       = bus.pixel_y - Y_MATRIX;
    col      = dx >> TILE_ORDER;
    row      = dy >> TILE_ORDER;
    bcol     = {6'd0, bomb_col};
    brow     = {7'd0, bomb_row};
    // Larger minus smaller keeps the distance unsigned, so no edge aliasing occurs.
    col_diff = (col >= bcol) ? (col - bcol) : (bcol - col);
    row_diff = (row >= brow) ? (row - brow) : (brow - row);
    in_row_arm = (row == brow) && (col_diff <= REACH);
    in_col_arm = (col == bcol) && (row_diff <= REACH);
    blast_hit  = on_board && (in_row_arm || in_col_arm);
  end

  // Next-state and counter logic.
  always_comb begin
    state_n     = state;
    bomb_col_n  = bomb_col;
    bomb_row_n  = bomb_row;
    fuse_cnt_n  = fuse_cnt;
    blast_cnt_n = blast_cnt;

    if (bus.game_over) begin
      state_n     = IDLE;
      fuse_cnt_n  = 8'd0;
      blast_cnt_n = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.place_req) begin
            bomb_col_n = bus.player_col;
            bomb_row_n = bus.player_row;
            state_n    = PLACE_WAIT;
          end
        end
        PLACE_WAIT: begin
          if (bus.sof) state_n = PLACING;
        end
        PLACING: begin
          if (bus.sof) begin
            state_n    = ARMED;
            fuse_cnt_n = FUSE_FRAMES;
          end
        end
        ARMED: begin
          if (bus.sof) begin
            if (fuse_cnt == 8'd1) begin
              state_n     = BLAST;
              fuse_cnt_n  = 8'd0;
              blast_cnt_n = BLAST_FRAMES;
            end else begin
              fuse_cnt_n = fuse_cnt - 8'd1;
            end
          end
        end
        BLAST: begin
          if (bus.sof) begin
            if (blast_cnt == 8'd1) begin
              state_n     = IDLE;
              blast_cnt_n = 8'd0;
            end else begin
              blast_cnt_n = blast_cnt - 8'd1;
            end
          end
        end
        default: begin
          state_n     = IDLE;
          fuse_cnt_n  = 8'd0;
          blast_cnt_n = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      bomb_col        <= 5'd0;
      bomb_row        <= 4'd0;
      fuse_cnt        <= 8'd0;
      blast_cnt       <= 8'd0;
      add_user_bomb_q <= 1'b0;
      explosion_q     <= 1'b0;
      bomb_active_q   <= 1'b0;
    end else begin
      state           <= state_n;
      bomb_col        <= bomb_col_n;
      bomb_row        <= bomb_row_n;
      fuse_cnt        <= fuse_cnt_n;
      blast_cnt       <= blast_cnt_n;
      // Status outputs follow the next state so they line up with the state register.
      add_user_bomb_q <= (state_n == PLACING);
      bomb_active_q   <= (state_n != IDLE);
      explosion_q     <= !bus.game_over && (state == BLAST) && blast_hit;
    end
  end

  assign bus.add_user_bomb  = add_user_bomb_q;
  assign bus.explosion      = explosion_q;
  assign bus.bomb_active    = bomb_active_q;
  assign bus.fuse_remaining = fuse_cnt;
  assign bus.state          = state;

endmodule

// File: tb/tb_bomb_blast_controller.sv
// Randomized bench for bomb_blast_controller. It checks every cycle against a
// frame-counting reference model of the bomb lifecycle and of the blast cross.
module tb_bomb_blast_controller;

  localparam int XM    = 32;
  localparam int YM    = 96;
  localparam int NCOLS = 17;
  localparam int NROWS = 11;
  localparam int TILE  = 32;
  localparam int FUSE  = 3;
  localparam int BLST  = 2;
  localparam int RAD   = 2;

  logic clk;
  logic rst_n;
  bomb_blast_if bus();

  bomb_blast_controller #(
    .FUSE_FRAMES (8'd3),
    .BLAST_FRAMES(8'd2),
    .RADIUS      (3'd2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Reference model. A bomb is tracked as a waiting flag, a placing flag and
  // frame counts for the fuse and the blast.
  bit m_wait, m_placing;
  int m_fuse, m_blast;
  int m_bc, m_br;
  bit go_level;
  logic [0:0] exp_q[$];

  function automatic bit in_region(input int x, input int y, input int bc, input int br);
    int c, r, dc, dr;
    if (x < XM || x >= XM + NCOLS * TILE || y < YM || y >= YM + NROWS * TILE) return 1'b0;
    c  = (x - XM) / TILE;
    r  = (y - YM) / TILE;
    dc = (c > bc) ? c - bc : bc - c;
    dr = (r > br) ? r - br : br - r;
    return ((r == br) && (dc <= RAD)) || ((c == bc) && (dr <= RAD));
  endfunction

  function automatic bit model_busy();
    return m_wait || m_placing || (m_fuse > 0) || (m_blast > 0);
  endfunction

  task automatic model_clear();
    m_wait = 0; m_placing = 0; m_fuse = 0; m_blast = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input int c, input int r,
                            input bit g, input int x, input int y);
    exp_q.push_back(!g && (m_blast > 0) && in_region(x, y, m_bc, m_br));
    if (g) begin
      model_clear();
    end else if (!model_busy()) begin
      if (p) begin m_wait = 1; m_bc = c; m_br = r; end
    end else if (m_wait) begin
      if (s) begin m_wait = 0; m_placing = 1; end
    end else if (m_placing) begin
      if (s) begin m_placing = 0; m_fuse = FUSE; end
    end else if (m_fuse > 0) begin
      if (s) begin
        m_fuse--;
        if (m_fuse == 0) m_blast = BLST;
      end
    end else if (s) begin
      m_blast--;
    end
  endtask

  // Driver: apply inputs at the negedge, update the model at the posedge,
  // and compare outputs at the following negedge.
  task automatic cycle(input bit s, input bit p, input int c, input int r,
                       input bit g, input int x, input int y);
    logic [0:0] e;
    bus.sof        = s;
    bus.place_req  = p;
    bus.player_col = 5'(c);
    bus.player_row = 4'(r);
    bus.game_over  = g;
    bus.pixel_x    = 11'(x);
    bus.pixel_y    = 11'(y);
    @(posedge clk);
    model_step(s, p, c, r, g, x, y);
    @(negedge clk);
    e = exp_q.pop_front();
    check("explosion", 32'(bus.explosion), 32'(e));
    check("add_user_bomb", 32'(bus.add_user_bomb), 32'(m_placing));
    check("bomb_active", 32'(bus.bomb_active), 32'(model_busy()));
    check("fuse_remaining", 32'(bus.fuse_remaining), 32'(m_fuse));
  endtask

  // One frame: sof on the first cycle, then a sweep that visits every tile,
  // then random pixels that include off-board positions.
  task automatic frame(input int len);
    int x, y, t, ox, oy;
    cycle(1, 0, 0, 0, go_level, 0, 0);
    for (int i = 1; i < len; i++) begin
      if (i <= NROWS * NCOLS) begin
        t  = i - 1;
        ox = (t % 3 == 0) ? 0 : (t % 3 == 1) ? 31 : int'($urandom_range(1, 30));
        oy = (t % 2 == 0) ? 31 : int'($urandom_range(0, 31));
        x  = XM + (t % NCOLS) * TILE + ox;
        y  = YM + (t / NCOLS) * TILE + oy;
      end else begin
        x = $urandom_range(0, 700);
        y = $urandom_range(0, 520);
      end
      cycle(0, 0, 0, 0, go_level, x, y);
    end
  endtask

  task automatic place(input int c, input int r, input bit with_sof);
    cycle(with_sof, 1, c, r, go_level, $urandom_range(0, 700), $urandom_range(0, 520));
    cycle(0, 0, 0, 0, go_level, 0, 0);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) frame(200);
  endtask

  initial begin
    rst_n = 1'b0;
    go_level = 0;
    model_clear();
    m_bc = 0; m_br = 0;
    bus.sof = 0; bus.place_req = 0; bus.player_col = 0; bus.player_row = 0;
    bus.game_over = 0; bus.pixel_x = 0; bus.pixel_y = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_add", 32'(bus.add_user_bomb), 32'd0);
    check("reset_expl", 32'(bus.explosion), 32'd0);
    check("reset_active", 32'(bus.bomb_active), 32'd0);
    check("reset_fuse", 32'(bus.fuse_remaining), 32'd0);
    rst_n = 1'b1;

    // Basic lifecycle and blast shape with the bomb at (4,2).
    frame(50);
    place(4, 2, 0);
    run_frames(8);

    // Corner bomb clips to on-board tiles.
    place(0, 0, 0);
    run_frames(8);

    // Placement coincident with sof, then an ignored request while armed.
    place(16, 10, 1);
    run_frames(3);
    place(7, 5, 0);
    run_frames(5);

    // Abort while placing.
    place(8, 5, 0);
    frame(60);
    check("placing_before_abort", 32'(bus.add_user_bomb), 32'd1);
    cycle(0, 0, 0, 0, 1, 0, 0);
    run_frames(1);

    // Abort in the middle of a blast, then requests while game_over is held.
    place(3, 9, 0);
    run_frames(6);
    for (int i = 0; i < 20; i++)
      cycle(0, 0, 0, 0, 0, XM + 3 * TILE + 5, YM + 9 * TILE + 5);
    go_level = 1;
    for (int i = 0; i < 5; i++) begin
      place(5, 5, 0);
      cycle(1, 0, 0, 0, 1, 0, 0);
    end
    go_level = 0;
    run_frames(1);

    // Asynchronous reset in the middle of a blast.
    place(10, 4, 0);
    run_frames(6);
    check("in_blast_before_reset", 32'(m_blast > 0), 32'(bus.bomb_active));
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_add", 32'(bus.add_user_bomb), 32'd0);
    check("async_rst_expl", 32'(bus.explosion), 32'd0);
    check("async_rst_active", 32'(bus.bomb_active), 32'd0);
    check("async_rst_fuse", 32'(bus.fuse_remaining), 32'd0);
    model_clear();
    m_bc = 0; m_br = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_frames(2);

    // Random traffic.
    for (int i = 0; i < 8000; i++) begin
      int x, y;
      if ($urandom_range(0, 3) != 0) begin
        x = XM + $urandom_range(0, NCOLS * TILE - 1);
        y = YM + $urandom_range(0, NROWS * TILE - 1);
      end else begin
        x = $urandom_range(0, 2047);
        y = $urandom_range(0, 2047);
      end
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, NCOLS - 1), $urandom_range(0, NROWS - 1),
            $urandom_range(0, 299) == 0, x, y);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
